// File: rtl/ctech_lib_sync_filter_pkg.sv
// Shared constants, filter-action encoding and counter sizing for the sync/filter slice.
package ctech_lib_sync_filter_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int GLITCH_CNT_W    = 8;
  localparam int MAX_FILTER_CNT  = 255;

  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_COUNT  = 2'd1,
    ACT_UPDATE = 2'd2,
    ACT_ABORT  = 2'd3
  } filt_act_e;

  // Bypass (n == 0) has no counter, but a 1-bit floor keeps declarations legal.
  function automatic int filt_cnt_w(int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ctech_lib_sync_filter_chan.sv
// One channel: synchronizer chain, stable-count filter, edge pulses and glitch counter.
// Glitch counter is built only when CTECH_LIB_SYNC_FILTER_GLITCH_CNT_EN is defined.
module ctech_lib_sync_filter_chan
  import ctech_lib_sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 3,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    d,
  input  logic                    glitch_clr,
  output logic                    o,
  output logic                    rise_p,
  output logic                    fall_p,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   o_q;
  logic                   rejected;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (FILTER_CNT == 0) begin : g_bypass
    always_ff @(posedge clk) begin
      if (rst) begin
        o <= RST_VAL;
      end else begin
        o <= sync;
      end
    end

    assign rejected = 1'b0;
  end else begin : g_filter
    localparam int CW = filt_cnt_w(FILTER_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          o_d;
    filt_act_e     act;

    // A return to the current level with a partial count is the rejected glitch.
    always_comb begin
      act = ACT_HOLD;
      if (sync == o) begin
        act = (cnt_q != '0) ? ACT_ABORT : ACT_HOLD;
      end else if (cnt_q == CNT_LAST) begin
        act = ACT_UPDATE;
      end else begin
        act = ACT_COUNT;
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      o_d   = o;
      case (act)
        ACT_COUNT:  cnt_d = cnt_q + CW'(1);
        ACT_UPDATE: begin
          cnt_d = '0;
          o_d   = sync;
        end
        ACT_ABORT:  cnt_d = '0;
        default:    ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        o     <= RST_VAL;
      end else begin
        cnt_q <= cnt_d;
        o     <= o_d;
      end
    end

    assign rejected = (act == ACT_ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= RST_VAL;
    end else begin
      o_q <= o;
    end
  end

  assign rise_p = o & ~o_q;
  assign fall_p = ~o & o_q;

`ifdef CTECH_LIB_SYNC_FILTER_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  // Clear wins over a same-cycle rejection; the count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= '0;
    end else if (glitch_clr) begin
      glitch_q <= '0;
    end else if (rejected && (glitch_q != GLITCH_CNT_MAX)) begin
      glitch_q <= glitch_q + GLITCH_CNT_W'(1);
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_glitch;

  assign unused_glitch = &{1'b0, glitch_clr, rejected};
  assign glitch_cnt    = '0;
`endif

endmodule

// File: rtl/ctech_lib_sync_filter_rst.sv
// Multi-bit synchronizer with glitch filter and edge pulses; one independent channel per bit.
// Optional glitch counters: define CTECH_LIB_SYNC_FILTER_GLITCH_CNT_EN.
module ctech_lib_sync_filter_rst
  import ctech_lib_sync_filter_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CNT  = 3,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              d,
  input  logic                          glitch_clr,
  output logic [WIDTH-1:0]              o,
  output logic [WIDTH-1:0]              rise_p,
  output logic [WIDTH-1:0]              fall_p,
  output logic [WIDTH*GLITCH_CNT_W-1:0] glitch_cnt
);

  if (WIDTH < 1) begin : g_bad_width
    $error("ctech_lib_sync_filter_rst: WIDTH must be at least 1");
  end

  if ((SYNC_STAGES < MIN_SYNC_STAGES) || (SYNC_STAGES > MAX_SYNC_STAGES)) begin : g_bad_stages
    $error("ctech_lib_sync_filter_rst: SYNC_STAGES out of range 2..4");
  end

  if ((FILTER_CNT < 0) || (FILTER_CNT > MAX_FILTER_CNT)) begin : g_bad_filter
    $error("ctech_lib_sync_filter_rst: FILTER_CNT out of range 0..255");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    ctech_lib_sync_filter_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RST_VAL    (RST_VAL)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .d         (d[i]),
      .glitch_clr(glitch_clr),
      .o         (o[i]),
      .rise_p    (rise_p[i]),
      .fall_p    (fall_p[i]),
      .glitch_cnt(glitch_cnt[i*GLITCH_CNT_W +: GLITCH_CNT_W])
    );
  end

endmodule
